// File: rtl/alu_exec_stage.sv
// Registered ALU execute stage with a two-entry (head/skid) output buffer.
// Optional per-entry signed-overflow flag is enabled by defining ALU_OVF_EN.
module alu_exec_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             bad_op
`ifdef ALU_OVF_EN
    ,
    output logic             ovf
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic             acc;
    logic             pop;
    logic             load_head_new;
    logic             load_head_skid;
    logic             load_skid;

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             slt;
    logic [WIDTH-1:0] wr_result;
    logic             wr_zero;
    logic             wr_bad;

    logic [WIDTH-1:0] head_result_reg, skid_result_reg;
    logic             head_zero_reg, skid_zero_reg;
    logic             head_bad_reg, skid_bad_reg;

`ifdef ALU_OVF_EN
    logic             wr_ovf;
    logic             head_ovf_reg, skid_ovf_reg;
`endif

    // Handshake flags come straight from the occupancy register.
    assign in_ready  = (state_reg != FULL);
    assign out_valid = (state_reg != EMPTY);
    assign acc       = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    assign sum  = op_a + op_b;
    assign diff = op_a - op_b;
    assign slt  = ($signed(op_a) < $signed(op_b));

    always_comb begin
        wr_result = '0;
        wr_bad    = 1'b0;
`ifdef ALU_OVF_EN
        wr_ovf    = 1'b0;
`endif
        case (alu_ctrl)
            4'b0000: wr_result = op_a & op_b;
            4'b0001: wr_result = op_a | op_b;
            4'b0010: begin
                wr_result = sum;
`ifdef ALU_OVF_EN
                wr_ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
`endif
            end
            4'b0110: begin
                wr_result = diff;
`ifdef ALU_OVF_EN
                wr_ovf = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != op_a[WIDTH-1]);
`endif
            end
            4'b0111: wr_result = {{(WIDTH-1){1'b0}}, slt};
            4'b1100: wr_result = ~(op_a | op_b);
            default: wr_bad = 1'b1;
        endcase
        // Zero flag covers the forced-zero result of an unsupported code too.
        wr_zero = (wr_result == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        load_head_new  = 1'b0;
        load_head_skid = 1'b0;
        load_skid      = 1'b0;
        case (state_reg)
            EMPTY: begin
                if (acc) begin
                    load_head_new = 1'b1;
                    state_next    = ONE;
                end
            end
            ONE: begin
                if (acc && pop) begin
                    load_head_new = 1'b1;
                end else if (acc) begin
                    load_skid  = 1'b1;
                    state_next = FULL;
                end else if (pop) begin
                    state_next = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    load_head_skid = 1'b1;
                    state_next     = ONE;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_result_reg <= '0;
            head_zero_reg   <= 1'b0;
            head_bad_reg    <= 1'b0;
            skid_result_reg <= '0;
            skid_zero_reg   <= 1'b0;
            skid_bad_reg    <= 1'b0;
`ifdef ALU_OVF_EN
            head_ovf_reg    <= 1'b0;
            skid_ovf_reg    <= 1'b0;
`endif
        end else begin
            if (load_head_new) begin
                head_result_reg <= wr_result;
                head_zero_reg   <= wr_zero;
                head_bad_reg    <= wr_bad;
`ifdef ALU_OVF_EN
                head_ovf_reg    <= wr_ovf;
`endif
            end else if (load_head_skid) begin
                head_result_reg <= skid_result_reg;
                head_zero_reg   <= skid_zero_reg;
                head_bad_reg    <= skid_bad_reg;
`ifdef ALU_OVF_EN
                head_ovf_reg    <= skid_ovf_reg;
`endif
            end
            if (load_skid) begin
                skid_result_reg <= wr_result;
                skid_zero_reg   <= wr_zero;
                skid_bad_reg    <= wr_bad;
`ifdef ALU_OVF_EN
                skid_ovf_reg    <= wr_ovf;
`endif
            end
        end
    end

    assign result = head_result_reg;
    assign zero   = head_zero_reg;
    assign bad_op = head_bad_reg;
`ifdef ALU_OVF_EN
    assign ovf    = head_ovf_reg;
`endif

endmodule

// File: doc/alu_exec_stage.md
# alu_exec_stage

Registered execute stage that sits directly downstream of the ALU control decoder. It consumes the 4-bit ALU control code together with two operands and computes the ALU result. The result is presented to the memory/writeback side through a valid/ready handshake. A two-entry output buffer decouples the upstream ready from the downstream ready, so `in_ready` never depends combinationally on `out_ready`.

## Interface
- `WIDTH`, default 32: operand and result width in bits (≥ 2).
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  reset; asynchronous, active-high.
- `in_valid`  input  1  operands and control code are valid.
- `in_ready`  output  1  stage can accept; driven only from state registers.
- `alu_ctrl`  input  4  code from the ALU control decoder.
- `op_a`, `op_b`  input  WIDTH  operands (rs, rt/immediate).
- `out_valid`  output  1  head-of-buffer result valid.
- `out_ready`  input  1  consumer accepts the head entry.
- `result`  output  WIDTH  head-entry result.
- `zero`  output  1  head entry's result == 0 (branch compare).
- `bad_op`  output  1  head entry carried an unsupported code.
- `ovf`  output  1  signed overflow of ADD/SUB; exists only with `ALU_OVF_EN`.

## Operation
- Decode of `alu_ctrl`:
  - 0000 → AND.
  - 0001 → OR.
  - 0010 → ADD, modulo 2^WIDTH.
  - 0110 → SUB (a−b), modulo 2^WIDTH.
  - 0111 → SLT: signed two's-complement a<b gives 1, zero-extended.
  - 1100 → NOR.
  - Any other code → result 0, `bad_op`=1. The entry is still passed downstream.
- The per-entry `zero` flag is computed from the final result, including the bad-op zero.
- Storage is a 2-entry FIFO (head, skid) holding {result, zero, bad_op[, ovf]}.
- Occupancy states:
  - EMPTY: `in_ready`=1, `out_valid`=0.
  - ONE: `in_ready`=1, `out_valid`=1.
  - FULL: `in_ready`=0, `out_valid`=1.
- Accept event: `acc` = `in_valid & in_ready`. Pop event: `pop` = `out_valid & out_ready`.
- State transitions, evaluated at each rising edge:
  - EMPTY + acc → ONE. New entry goes to head.
  - ONE + acc + pop → ONE. New entry replaces head.
  - ONE + acc + no pop → FULL. New entry goes to skid.
  - ONE + pop + no acc → EMPTY.
  - FULL + pop → ONE. Skid moves to head.
  - All other combinations hold state.
- Order is strictly preserved. No entry is dropped or duplicated.
- `in_valid` while `in_ready`=0 has no effect. Inputs are not sampled.

## Timing
- Latency: an entry accepted at edge N is visible on `result` after edge N, given an empty buffer or a pop at the same edge.
- Throughput: 1 entry/cycle when `out_ready` is held high.
- `in_ready` falls in the cycle after the edge that filled the skid entry. It rises in the cycle after the pop from FULL.
- Head outputs stay stable while `out_valid`=1 and `out_ready`=0.
- Reset state, asynchronous on `rst`=1:
  - state EMPTY.
  - `out_valid`=0, `in_ready`=1.
  - `result`=0, `zero`=0, `bad_op`=0, `ovf`=0.
- Reset mid-operation discards all buffered entries. The first accept is possible at the first rising edge after `rst` deasserts.
- Outputs are registered. The only combinational logic is decode/arithmetic from the inputs into the write-data mux.

## Configuration
- `ALU_OVF_EN` defined:
  - `ovf` port present. It is stored per entry.
  - ADD sets `ovf` when the operands have the same sign and the result sign differs.
  - SUB sets `ovf` when the operands have different signs and the result sign differs from `op_a`.
  - All other codes give `ovf`=0.
- `ALU_OVF_EN` undefined:
  - No `ovf` port and no storage bit for it.
  - All other behaviour is identical.

## Test plan
- Reset then single ops, WIDTH=32, `out_ready`=1:
  - ADD 5+7 → `result`=12, `zero`=0, one cycle after accept.
  - SUB 9−9 → 0, `zero`=1.
  - AND 0xF0F0&0xFF00 → 0xF000.
  - OR → 0xFFF0.
  - NOR 0,0 → 0xFFFFFFFF.
- SLT signed: a=0xFFFFFFFF (−1), b=1 → 1. a=1, b=0xFFFFFFFF → 0.
- Backpressure with `out_ready`=0 and three back-to-back inputs 1+1, 2+2, 3+3:
  - First two accepted; `in_ready`=0 from the cycle after the second accept.
  - Raise `out_ready` → results out in order 2, 4, 6. The third is accepted after the first pop.
- Unsupported code 0101 with a=3, b=4 → `result`=0, `zero`=1, `bad_op`=1. The entry is delivered normally.
- Assert `rst` while FULL → `out_valid`=0 and `in_ready`=1 immediately. Buffered results never appear.
- With `ALU_OVF_EN`:
  - ADD 0x7FFFFFFF+1 → `result`=0x80000000, `ovf`=1.
  - SUB 0x80000000−1 → `ovf`=1.
  - ADD 1+1 → `ovf`=0.
